// File: rtl/frame_sync_ctrl_pkg.sv
// Shared types and default constants for the receive-side frame synchroniser.
package frame_sync_ctrl_pkg;

    // Lock/flywheel states; encoding is visible on the sync_state output.
    typedef enum logic [1:0] {
        StHunt     = 2'd0,
        StConfirm  = 2'd1,
        StLock     = 2'd2,
        StFlywheel = 2'd3
    } sync_state_t;

    localparam int unsigned HDR_W_DEF   = 4;
    localparam int unsigned PAY_W_DEF   = 12;
    localparam int unsigned FRAME_W_DEF = HDR_W_DEF + PAY_W_DEF;

    localparam logic [HDR_W_DEF-1:0] HEADER_DEF = 4'b0110;

endpackage

// File: rtl/frame_sync_ctrl_if.sv
// Bit-stream input and frame/lock outputs of the frame synchroniser.
interface frame_sync_ctrl_if #(
    parameter int unsigned PAY_W = 12
);
    logic             bit_in;
    logic             bit_valid;
    logic [PAY_W-1:0] r_frame_data;
    logic             frame_valid;
    logic             frame_correct;
    logic             frame_err;
    logic [1:0]       sync_state;

    // Upstream demodulator side: supplies bits, observes frames.
    modport master (
        output bit_in,
        output bit_valid,
        input  r_frame_data,
        input  frame_valid,
        input  frame_correct,
        input  frame_err,
        input  sync_state
    );

    // Synchroniser side.
    modport slave (
        input  bit_in,
        input  bit_valid,
        output r_frame_data,
        output frame_valid,
        output frame_correct,
        output frame_err,
        output sync_state
    );
endinterface

// File: rtl/frame_sync_ctrl_sync_shift_reg.sv
// Frame-wide shift register with bit counter and frame boundary flag.
// sh_next is the register contents including the bit being consumed this cycle.
module frame_sync_ctrl_sync_shift_reg
    import frame_sync_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               hunt,     // no frame alignment established
    input  logic               cnt_clr,  // header found while hunting: restart count
    output logic [FRAME_W-1:0] sh_next,
    output logic               boundary
);
    localparam int unsigned CntW = $clog2(FRAME_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_W - 1);

    // Only FRAME_W-1 bits of history are kept; the newest bit completes the frame.
    logic [FRAME_W-2:0] sh_q;
    logic [CntW-1:0]    bit_cnt_q;

    // Next shift contents and boundary detection for the bit being consumed.
    always_comb begin
        sh_next  = {sh_q, bit_in};
        boundary = !hunt && bit_valid && (bit_cnt_q == LastCnt);
    end

    // History and position-in-frame counter advance one step per valid bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sh_q      <= '0;
            bit_cnt_q <= '0;
        end else if (bit_valid) begin
            sh_q <= sh_next[FRAME_W-2:0];
            if (cnt_clr || (bit_cnt_q == LastCnt)) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame synchroniser: hunts for the header, confirms alignment, then runs a
// lock/flywheel state machine and strobes out each aligned payload.
module frame_sync_ctrl
    import frame_sync_ctrl_pkg::*;
#(
    parameter int unsigned       HDR_W     = HDR_W_DEF,
    parameter int unsigned       PAY_W     = PAY_W_DEF,
    parameter logic [HDR_W-1:0]  HEADER    = HEADER_DEF,
    parameter int unsigned       CONFIRM_N = 2,
    parameter int unsigned       MISS_M    = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    frame_sync_ctrl_if.slave     bus
);
    localparam int unsigned FRAME_W = HDR_W + PAY_W;
    localparam int unsigned HitW    = $clog2(CONFIRM_N + 1);
    localparam int unsigned MissW   = $clog2(MISS_M + 1);

    sync_state_t        state_q, state_d;
    logic [HitW-1:0]    hit_cnt_q, hit_cnt_d, hit_inc;
    logic [MissW-1:0]   miss_cnt_q, miss_cnt_d, miss_inc;
    logic [PAY_W-1:0]   frame_data_q, frame_data_d;
    logic               frame_valid_q, frame_valid_d;
    logic               frame_err_q, frame_err_d;

    logic [FRAME_W-1:0] sh_next;
    logic               boundary;
    logic               hdr_hit;
    logic               hunt;
    logic               cnt_clr;
    logic [PAY_W-1:0]   payload;

    frame_sync_ctrl_sync_shift_reg #(
        .FRAME_W (FRAME_W)
    ) u_shift (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .bit_in    (bus.bit_in),
        .bit_valid (bus.bit_valid),
        .hunt      (hunt),
        .cnt_clr   (cnt_clr),
        .sh_next   (sh_next),
        .boundary  (boundary)
    );

    // Header match and payload extraction on the window including the current bit.
    always_comb begin
        hdr_hit  = (sh_next[HDR_W-1:0] == HEADER);
        payload  = sh_next[FRAME_W-1:HDR_W];
        hunt     = (state_q == StHunt);
        cnt_clr  = hunt && bus.bit_valid && hdr_hit;
        hit_inc  = hit_cnt_q + HitW'(1);
        miss_inc = miss_cnt_q + MissW'(1);
    end

    // Next-state, counter and output decisions; only frame boundaries act outside HUNT.
    always_comb begin
        state_d       = state_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (cnt_clr) begin
                    state_d   = StConfirm;
                    hit_cnt_d = '0;
                end
            end
            StConfirm: begin
                if (boundary) begin
                    if (hdr_hit) begin
                        hit_cnt_d = hit_inc;
                        if (hit_inc == HitW'(CONFIRM_N)) begin
                            state_d = StLock;
                        end
                    end else begin
                        state_d    = StHunt;
                        hit_cnt_d  = '0;
                        miss_cnt_d = '0;
                    end
                end
            end
            StLock: begin
                if (boundary) begin
                    frame_valid_d = 1'b1;
                    frame_data_d  = payload;
                    if (!hdr_hit) begin
                        frame_err_d = 1'b1;
                        // A single allowed miss means the first miss already loses sync.
                        if (MISS_M == 1) begin
                            state_d    = StHunt;
                            hit_cnt_d  = '0;
                            miss_cnt_d = '0;
                        end else begin
                            state_d    = StFlywheel;
                            miss_cnt_d = MissW'(1);
                        end
                    end
                end
            end
            StFlywheel: begin
                if (boundary) begin
                    frame_valid_d = 1'b1;
                    frame_data_d  = payload;
                    if (hdr_hit) begin
                        state_d    = StLock;
                        miss_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        miss_cnt_d  = miss_inc;
                        if (miss_inc == MissW'(MISS_M)) begin
                            state_d    = StHunt;
                            hit_cnt_d  = '0;
                            miss_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d    = StHunt;
                hit_cnt_d  = '0;
                miss_cnt_d = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset overrides any pending frame event.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= StHunt;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.r_frame_data  = frame_data_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.frame_correct = (state_q == StLock);
    assign bus.sync_state    = state_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: directed phases plus random payloads/gaps, with a
// bit-history reference model feeding a scoreboard of expected frame strobes.
module tb_frame_sync_ctrl;
    localparam logic [3:0]  HDR = 4'b0110;
    localparam logic [11:0] PAY = 12'hA5C;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    frame_sync_ctrl_if #(.PAY_W(12)) bus ();

    frame_sync_ctrl #(
        .HDR_W     (4),
        .PAY_W     (12),
        .HEADER    (4'b0110),
        .CONFIRM_N (2),
        .MISS_M    (3)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [11:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: last 16 received bits, and frame alignment as an anchor bit index.
    bit hist_q[$];
    int m_n, m_anchor, m_mode, m_hits, m_miss;

    int  n_frames = 0;
    int  n_errs   = 0;
    bit  rand_gaps = 1'b0;
    int  f0, e0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic void model_reset();
        hist_q.delete();
        exp_q.delete();
        m_n      = 0;
        m_anchor = 0;
        m_mode   = 0;
        m_hits   = 0;
        m_miss   = 0;
    endfunction

    function automatic void model_bit(input bit b);
        logic [15:0] win;
        bit          good;
        exp_t        e;
        hist_q.push_back(b);
        if (hist_q.size() > 16) void'(hist_q.pop_front());
        m_n++;
        win = '0;
        foreach (hist_q[k]) win = {win[14:0], hist_q[k]};
        good = (win[3:0] == HDR);
        if (m_mode == 0) begin
            if (good) begin
                m_mode   = 1;
                m_anchor = m_n;
                m_hits   = 0;
            end
            return;
        end
        if (((m_n - m_anchor) % 16) != 0) return;
        if (m_mode >= 2) begin
            e.data = win[15:4];
            e.err  = !good;
            exp_q.push_back(e);
        end
        case (m_mode)
            1: if (good) begin
                   m_hits++;
                   if (m_hits == 2) m_mode = 2;
               end else begin
                   m_mode = 0;
               end
            2: if (!good) begin
                   m_mode = 3;
                   m_miss = 1;
               end
            3: if (good) begin
                   m_mode = 2;
                   m_miss = 0;
               end else begin
                   m_miss++;
                   if (m_miss == 3) m_mode = 0;
               end
            default: m_mode = 0;
        endcase
    endfunction

    // One clock: drive, let the DUT sample, then advance the model.
    task automatic step(input logic rst, input logic v, input logic b);
        sys_rst       = rst;
        bus.bit_valid = v;
        bus.bit_in    = b;
        @(posedge sys_clk);
        #1;
        if (rst) model_reset();
        else if (v) model_bit(b);
        sys_rst       = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int g;
        g = rand_gaps ? int'($urandom_range(0, 7)) : 3;
        repeat (g) step(1'b0, 1'b0, 1'($urandom));
        step(1'b0, 1'b1, b);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [11:0] p, input logic [3:0] h);
        send_bits({p, h}, 16);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b1, 1'b1, 1'($urandom));
    endtask

    // Monitor: every cycle compare state/lock and consume one expected frame per strobe.
    initial begin
        forever begin
            @(negedge sys_clk);
            check("sync_state", 32'(bus.sync_state), 32'(m_mode));
            check("frame_correct", 32'(bus.frame_correct), 32'(m_mode == 2));
            check("frame_valid", 32'(bus.frame_valid), 32'(exp_q.size() > 0));
            if (bus.frame_valid && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("frame_data", 32'(bus.r_frame_data), 32'(mon_e.data));
                check("frame_err", 32'(bus.frame_err), 32'(mon_e.err));
                n_frames++;
                if (mon_e.err) n_errs++;
            end else begin
                check("frame_err_idle", 32'(bus.frame_err), 32'(1'b0));
                exp_q.delete();
            end
        end
    end

    initial begin
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        model_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0);

        // Continuous good frames: HUNT -> CONFIRM -> LOCK -> emit.
        send_bits(16'(HDR), 4);
        check("hunt_to_confirm", 32'(bus.sync_state), 1);
        send_frame(PAY, HDR);
        check("confirm_hit1", 32'(bus.sync_state), 1);
        send_frame(PAY, HDR);
        check("confirm_to_lock", 32'(bus.sync_state), 2);
        check("lock_frame_correct", 32'(bus.frame_correct), 1);
        send_frame(PAY, HDR);
        check("lock_emit_valid", 32'(bus.frame_valid), 1);
        check("lock_emit_data", 32'(bus.r_frame_data), 32'(PAY));

        // Single bad header in LOCK -> FLYWHEEL with error, then back.
        send_frame(PAY, 4'b0111);
        check("miss_err", 32'(bus.frame_err), 1);
        check("miss_state", 32'(bus.sync_state), 3);
        check("miss_frame_correct", 32'(bus.frame_correct), 0);
        check("miss_still_emits", 32'(bus.frame_valid), 1);
        send_frame(PAY, HDR);
        check("fly_back_to_lock", 32'(bus.sync_state), 2);

        // Mid-frame reset held 3 cycles.
        send_bits(16'h05A3, 6);
        do_reset(3);
        check("rst_state", 32'(bus.sync_state), 0);
        check("rst_data", 32'(bus.r_frame_data), 0);
        check("rst_valid", 32'(bus.frame_valid), 0);
        check("rst_correct", 32'(bus.frame_correct), 0);
        check("rst_err", 32'(bus.frame_err), 0);

        // Relock, then three consecutive misses drop to HUNT.
        send_bits(16'(HDR), 4);
        repeat (3) send_frame(PAY, HDR);
        e0 = n_errs;
        send_frame(PAY, 4'b0111);
        send_frame(PAY, 4'b1110);
        send_frame(PAY, 4'b0000);
        check("three_miss_state", 32'(bus.sync_state), 0);
        step(1'b0, 1'b0, 1'b0);
        check("three_miss_errs", 32'(n_errs - e0), 3);
        f0 = n_frames;
        repeat (2) send_frame(PAY, HDR);
        step(1'b0, 1'b0, 1'b0);
        check("no_emit_after_hunt", 32'(n_frames - f0), 0);

        // False header inside payload 6F6: CONFIRM, miss at next boundary, then real lock.
        do_reset(1);
        send_bits(16'h0006, 4);
        check("false_confirm", 32'(bus.sync_state), 1);
        send_bits(16'h00F6, 8);
        send_bits(16'(HDR), 4);
        send_bits(16'h000A, 4);
        check("false_confirm_miss", 32'(bus.sync_state), 0);
        send_bits(16'h005C, 8);
        send_bits(16'(HDR), 4);
        check("realign_confirm", 32'(bus.sync_state), 1);
        repeat (2) send_frame(PAY, HDR);
        check("realign_lock", 32'(bus.sync_state), 2);

        // Random bit_valid gaps: same payload sequence as continuous case.
        do_reset(1);
        rand_gaps = 1'b1;
        f0 = n_frames;
        send_bits(16'(HDR), 4);
        repeat (5) send_frame(PAY, HDR);
        step(1'b0, 1'b0, 1'b0);
        check("gap_frame_count", 32'(n_frames - f0), 3);
        check("gap_frame_data", 32'(bus.r_frame_data), 32'(PAY));

        // Random payloads, occasional bad headers and slips, against the model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) send_bit(1'($urandom));
            send_frame(12'($urandom), ($urandom_range(0, 4) == 0) ? 4'($urandom) : HDR);
        end

        repeat (4) step(1'b0, 1'b0, 1'b0);
        check("exp_queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
